// File: rtl/sdram_burst_sched_if.sv
// Request/acknowledge channel between the burst scheduler
// and the SDRAM command engine.
interface sdram_burst_sched_if #(
  parameter int ADDR_WIDTH = 24
);
  logic                  wr_burst_req;
  logic                  rd_burst_req;
  logic                  ref_req;
  logic [ADDR_WIDTH-1:0] burst_addr;
  logic                  cmd_ack;
  logic                  cmd_done;

  modport master (
    output wr_burst_req,
    output rd_burst_req,
    output ref_req,
    output burst_addr,
    input  cmd_ack,
    input  cmd_done
  );

  modport slave (
    input  wr_burst_req,
    input  rd_burst_req,
    input  ref_req,
    input  burst_addr,
    output cmd_ack,
    output cmd_done
  );
endinterface

// File: rtl/sdram_burst_sched.sv
// Picks write-burst, read-burst or refresh for the SDRAM command
// engine from FIFO levels; owns burst addresses and FIFO flush.
module sdram_burst_sched #(
  parameter int ADDR_WIDTH  = 24,
  parameter int LEVEL_WIDTH = 10,
  parameter int RFIFO_DEPTH = 512,
  parameter int BURST_LEN   = 8,
  parameter int REF_PERIOD  = 780,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MIN = '0,
  parameter logic [ADDR_WIDTH-1:0] ADDR_MAX = '1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_done,
  input  logic                   rd_en,
  input  logic                   flush,
  input  logic [LEVEL_WIDTH-1:0] wfifo_level,
  input  logic [LEVEL_WIDTH-1:0] rfifo_level,
  sdram_burst_sched_if.master    cmd,
  output logic                   wfifo_clr,
  output logic                   rfifo_clr,
  output logic                   ref_overrun,
  output logic                   busy
);

  localparam int RCW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam logic [RCW-1:0] REF_LAST = RCW'(REF_PERIOD - 1);
  localparam logic [LEVEL_WIDTH-1:0] WR_THR =
    LEVEL_WIDTH'(BURST_LEN);
  localparam logic [LEVEL_WIDTH-1:0] RD_THR =
    LEVEL_WIDTH'(RFIFO_DEPTH - BURST_LEN);
  localparam logic [ADDR_WIDTH:0] BL_EXT  = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0] MAX_EXT = {1'b0, ADDR_MAX};

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_BUSY, RD_REQ,
    RD_BUSY, REF_REQ, REF_BUSY, FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [RCW-1:0]        ref_cnt;
  logic                  ref_pend;
  logic                  flush_pend;
  logic                  last_wr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  w_el, r_el;
  logic                  ref_exp;
  logic                  wr_fin, rd_fin, in_flush;

  // Extra sum bit keeps the wrap test honest when ADDR_MAX is all ones
  function automatic logic [ADDR_WIDTH-1:0] addr_next(
    input logic [ADDR_WIDTH-1:0] a
  );
    logic [ADDR_WIDTH:0] s;
    s = {1'b0, a} + BL_EXT;
    return (s > MAX_EXT) ? ADDR_MIN : s[ADDR_WIDTH-1:0];
  endfunction

  assign w_el     = wfifo_level >= WR_THR;
  assign r_el     = rd_en && (rfifo_level <= RD_THR);
  assign ref_exp  = init_done && (ref_cnt == REF_LAST);
  assign in_flush = state_q == FLUSH;
  assign wr_fin   = (state_q == WR_BUSY) && cmd.cmd_done;
  assign rd_fin   = (state_q == RD_BUSY) && cmd.cmd_done;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (init_done) begin
          if (flush_pend || flush)
            state_d = FLUSH;
          else if (ref_pend)
            state_d = REF_REQ;
          else if (w_el && r_el)
            state_d = last_wr ? RD_REQ : WR_REQ;
          else if (w_el)
            state_d = WR_REQ;
          else if (r_el)
            state_d = RD_REQ;
        end
      end
      WR_REQ:   if (cmd.cmd_ack)  state_d = WR_BUSY;
      WR_BUSY:  if (cmd.cmd_done) state_d = IDLE;
      RD_REQ:   if (cmd.cmd_ack)  state_d = RD_BUSY;
      RD_BUSY:  if (cmd.cmd_done) state_d = IDLE;
      REF_REQ:  if (cmd.cmd_ack)  state_d = REF_BUSY;
      REF_BUSY: if (cmd.cmd_done) state_d = IDLE;
      FLUSH:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ref_cnt     <= '0;
      ref_pend    <= 1'b0;
      ref_overrun <= 1'b0;
      flush_pend  <= 1'b0;
      last_wr     <= 1'b0;
      wr_addr     <= ADDR_MIN;
      rd_addr     <= ADDR_MIN;
      addr_q      <= ADDR_MIN;
    end else begin
      state_q <= state_d;
      ref_cnt <= (!init_done || ref_exp) ? '0 : ref_cnt + 1'b1;
      if (ref_exp) begin
        ref_pend <= 1'b1;
        if (ref_pend) ref_overrun <= 1'b1;
      end else if (state_q == REF_REQ && cmd.cmd_ack) begin
        ref_pend <= 1'b0;
      end
      if (in_flush)
        flush_pend <= flush;
      else if (flush && state_q != IDLE)
        flush_pend <= 1'b1;
      // Latched only in IDLE so the address is frozen across the request
      if (state_q == IDLE)
        addr_q <= (state_d == RD_REQ) ? rd_addr : wr_addr;
      unique case (1'b1)
        in_flush: begin
          wr_addr <= ADDR_MIN;
          rd_addr <= ADDR_MIN;
          last_wr <= 1'b0;
        end
        wr_fin: begin
          wr_addr <= addr_next(wr_addr);
          last_wr <= 1'b1;
        end
        rd_fin: begin
          rd_addr <= addr_next(rd_addr);
          last_wr <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cmd.wr_burst_req = state_q == WR_REQ;
  assign cmd.rd_burst_req = state_q == RD_REQ;
  assign cmd.ref_req      = state_q == REF_REQ;
  assign cmd.burst_addr   = addr_q;
  assign wfifo_clr        = in_flush;
  assign rfifo_clr        = in_flush;
  assign busy             = state_q != IDLE;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Scoreboard bench for sdram_burst_sched: directed scenarios push
// expected requests, a monitor checks them as they appear.
module tb_sdram_burst_sched;

  localparam int AW = 24;
  localparam int LW = 10;
  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_RD  = 2'd1;
  localparam logic [1:0] K_CLR = 2'd2;

  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          rd_en = 1'b0;
  logic          flush = 1'b0;
  logic [LW-1:0] wfifo_level = '0;
  logic [LW-1:0] rfifo_level = '0;
  logic          wfifo_clr, rfifo_clr, ref_overrun, busy;

  logic          init_r = 1'b0;
  logic [LW-1:0] wf_r = '0;
  logic          wclr_r, rclr_r, ovr_r, busy_r;

  int   n_chk  = 0;
  int   n_fail = 0;
  int   ack_dly = 0;
  int   done_dly = 0;
  exp_t sb[$];

  sdram_burst_sched_if #(.ADDR_WIDTH(AW)) sif ();
  sdram_burst_sched_if #(.ADDR_WIDTH(AW)) rif ();

  sdram_burst_sched #(.ADDR_MAX(24'd31)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .rd_en(rd_en), .flush(flush),
    .wfifo_level(wfifo_level), .rfifo_level(rfifo_level),
    .cmd(sif), .wfifo_clr(wfifo_clr), .rfifo_clr(rfifo_clr),
    .ref_overrun(ref_overrun), .busy(busy)
  );

  sdram_burst_sched #(.REF_PERIOD(16)) dut_r (
    .clk(clk), .rst(rst), .init_done(init_r),
    .rd_en(1'b0), .flush(1'b0),
    .wfifo_level(wf_r), .rfifo_level(10'd0),
    .cmd(rif), .wfifo_clr(wclr_r), .rfifo_clr(rclr_r),
    .ref_overrun(ovr_r), .busy(busy_r)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string name,
                          input logic [31:0] act,
                          input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [AW-1:0] a);
    sb.push_back({k, a});
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq(name, sb.size(), 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (2) @(negedge clk);
    while (busy && t < 400) begin
      @(negedge clk);
      t++;
    end
    check_eq("idle_wait", 32'(busy), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_flush();
    push(K_CLR, '0);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    drain("flush_drain");
  endtask

  function automatic logic [2:0] rreqs();
    return {rif.wr_burst_req, rif.rd_burst_req, rif.ref_req};
  endfunction

  task automatic wait_r(input string name);
    int t = 0;
    while (rreqs() == 3'b000 && t < 30) begin
      @(negedge clk);
      t++;
    end
    check_eq(name, 32'(rreqs() != 3'b000), 1);
  endtask

  task automatic pulse_r(input logic is_ack);
    if (is_ack) rif.cmd_ack = 1'b1;
    else rif.cmd_done = 1'b1;
    @(negedge clk);
    rif.cmd_ack = 1'b0;
    rif.cmd_done = 1'b0;
  endtask

  // Command engine model for the main instance
  initial begin : engine
    sif.cmd_ack = 1'b0;
    sif.cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (sif.wr_burst_req || sif.rd_burst_req ||
                   sif.ref_req)) begin
        repeat (ack_dly) @(negedge clk);
        sif.cmd_ack = 1'b1;
        @(negedge clk);
        sif.cmd_ack = 1'b0;
        repeat (done_dly) @(negedge clk);
        sif.cmd_done = 1'b1;
        @(negedge clk);
        sif.cmd_done = 1'b0;
      end
    end
  end

  logic          pw, pr;
  logic [AW-1:0] pa;
  exp_t          e;
  logic [1:0]    kind;

  initial begin : monitor
    pw = 1'b0;
    pr = 1'b0;
    pa = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pw = 1'b0;
        pr = 1'b0;
      end else begin
        if (sif.wr_burst_req || sif.rd_burst_req) begin
          kind = sif.wr_burst_req ? K_WR : K_RD;
          if ((sif.wr_burst_req && !pw) ||
              (sif.rd_burst_req && !pr)) begin
            check_eq("req_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check_eq("req_kind", 32'(kind), 32'(e.kind));
              check_eq("req_addr", 32'(sif.burst_addr), 32'(e.addr));
            end
          end else begin
            check_eq("addr_stable", 32'(sif.burst_addr), 32'(pa));
          end
          check_eq("req_onehot",
                   int'(sif.wr_burst_req) + int'(sif.rd_burst_req) +
                   int'(sif.ref_req), 1);
        end
        if (wfifo_clr || rfifo_clr) begin
          check_eq("clr_expected", 32'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("clr_kind", 32'(e.kind), 32'(K_CLR));
            check_eq("clr_both", 32'({wfifo_clr, rfifo_clr}), 3);
          end
        end
        pw = sif.wr_burst_req;
        pr = sif.rd_burst_req;
        pa = sif.burst_addr;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rif.cmd_ack = 1'b0;
    rif.cmd_done = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_outs",
             32'({sif.wr_burst_req, sif.rd_burst_req, sif.ref_req,
                  wfifo_clr, rfifo_clr, ref_overrun, busy}), 0);
    check_eq("rst_addr", 32'(sif.burst_addr), 0);
    rst = 1'b0;

    // No requests before init completes
    wfifo_level = 10'd8;
    repeat (6) @(negedge clk);
    check_eq("no_req_init_low", 32'(busy), 0);

    // Reset in the middle of the second write
    ack_dly = 0;
    done_dly = 3;
    push(K_WR, 24'd0);
    push(K_WR, 24'd8);
    init_done = 1'b1;
    drain("t1_drain_a");
    wfifo_level = 10'd0;
    @(negedge clk);
    check_eq("t1_busy_before_rst", 32'(busy), 1);
    check_eq("t1_addr_before_rst", 32'(sif.burst_addr), 8);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t1_rst_outs",
             32'({sif.wr_burst_req, sif.rd_burst_req, sif.ref_req,
                  wfifo_clr, rfifo_clr, ref_overrun, busy}), 0);
    check_eq("t1_rst_addr", 32'(sif.burst_addr), 0);
    push(K_WR, 24'd0);
    wfifo_level = 10'd8;
    rst = 1'b0;
    drain("t1_drain_b");
    wfifo_level = 10'd0;
    wait_idle();

    // Slow engine, write-only traffic
    do_flush();
    ack_dly = 2;
    done_dly = 7;
    push(K_WR, 24'd0);
    push(K_WR, 24'd8);
    wfifo_level = 10'd8;
    drain("t2_drain");
    wfifo_level = 10'd0;
    wait_idle();

    // Round-robin, then reads only with wrap at 31
    do_flush();
    ack_dly = 0;
    done_dly = 0;
    push(K_WR, 24'd0);
    push(K_RD, 24'd0);
    push(K_WR, 24'd8);
    push(K_RD, 24'd8);
    wfifo_level = 10'd20;
    rfifo_level = 10'd0;
    rd_en = 1'b1;
    drain("t3_drain_a");
    wfifo_level = 10'd7;
    push(K_RD, 24'd16);
    push(K_RD, 24'd24);
    push(K_RD, 24'd0);
    drain("t3_drain_b");
    rd_en = 1'b0;
    wfifo_level = 10'd0;
    wait_idle();

    // Five write bursts wrapping at ADDR_MAX=31
    do_flush();
    push(K_WR, 24'd0);
    push(K_WR, 24'd8);
    push(K_WR, 24'd16);
    push(K_WR, 24'd24);
    push(K_WR, 24'd0);
    wfifo_level = 10'd8;
    drain("t4_drain");
    wfifo_level = 10'd0;
    wait_idle();

    // Flush while a read is busy
    do_flush();
    done_dly = 10;
    push(K_RD, 24'd0);
    rd_en = 1'b1;
    drain("t5_drain_a");
    repeat (2) @(negedge clk);
    push(K_CLR, '0);
    push(K_RD, 24'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("t5_no_early_clr", 32'({wfifo_clr, rfifo_clr}), 0);
    end
    drain("t5_drain_b");
    rd_en = 1'b0;
    wait_idle();

    // Refresh priority and overrun on the REF_PERIOD=16 instance
    @(negedge clk);
    init_r = 1'b1;
    wf_r = 10'd8;
    wait_r("r_first_seen");
    check_eq("r_first_wr", 32'(rreqs()), 32'(3'b100));
    check_eq("r_first_addr", 32'(rif.burst_addr), 0);
    repeat (20) @(negedge clk);
    check_eq("r_ovr_early", 32'(ovr_r), 0);
    check_eq("r_wr_held", 32'(rif.wr_burst_req), 1);
    repeat (15) @(negedge clk);
    check_eq("r_ovr_set", 32'(ovr_r), 1);
    repeat (4) @(negedge clk);
    pulse_r(1'b1);
    check_eq("r_req_drop", 32'(rreqs()), 0);
    check_eq("r_busy", 32'(busy_r), 1);
    pulse_r(1'b0);
    wait_r("r_ref_seen");
    check_eq("r_ref_prio", 32'(rreqs()), 32'(3'b001));
    pulse_r(1'b1);
    pulse_r(1'b0);
    wait_r("r_wr2_seen");
    check_eq("r_wr2", 32'(rreqs()), 32'(3'b100));
    check_eq("r_wr2_addr", 32'(rif.burst_addr), 8);
    wf_r = 10'd0;
    pulse_r(1'b1);
    pulse_r(1'b0);
    repeat (3) @(negedge clk);

    check_eq("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_burst_sched.md
Name: sdram_burst_sched

Overview:
- Single-clock scheduler between the write/read FIFOs and the SDRAM command engine.
- Watches FIFO fill levels and issues one of three requests to the command engine: write-burst, read-burst or auto-refresh.
- Generates burst start addresses with wrap-around and sequences FIFO clears on flush.
- Sits above the command engine; one outstanding command at a time.

Parameters:
- ADDR_WIDTH, 24, SDRAM word address width.
- LEVEL_WIDTH, 10, width of the FIFO level inputs.
- RFIFO_DEPTH, 512, read FIFO capacity in words.
- BURST_LEN, 8, words per burst. Power of two, ≤ RFIFO_DEPTH.
- REF_PERIOD, 780, clk cycles between refresh requests.
- ADDR_MIN, 0, first burst address.
- ADDR_MAX, 24'hFFFFFF, last word address. (ADDR_MAX−ADDR_MIN+1) is a multiple of BURST_LEN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- init_done  in  1  SDRAM init complete; no requests while low.
- rd_en  in  1  read streaming enabled.
- flush  in  1  pulse; clear FIFOs and restart addresses.
- wfifo_level  in  LEVEL_WIDTH  words in write FIFO.
- rfifo_level  in  LEVEL_WIDTH  words in read FIFO.
- wr_burst_req  out  1  write-burst request.
- rd_burst_req  out  1  read-burst request.
- ref_req  out  1  refresh request.
- burst_addr  out  ADDR_WIDTH  start address for the current wr/rd request.
- cmd_ack  in  1  command engine accepted the request.
- cmd_done  in  1  command engine finished the accepted command.
- wfifo_clr  out  1  write FIFO clear pulse.
- rfifo_clr  out  1  read FIFO clear pulse.
- ref_overrun  out  1  sticky: a refresh period expired while a refresh was still pending.
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE.
  - All outputs 0; burst_addr=ADDR_MIN.
  - Internal wr_addr=rd_addr=ADDR_MIN, ref_cnt=0, ref_pend=0, last_wr=0, flush_pend=0.
- Refresh timer:
  - ref_cnt counts while init_done=1, holds at 0 otherwise.
  - At ref_cnt==REF_PERIOD−1, ref_cnt wraps to 0 and ref_pend is set.
  - If ref_pend is already 1 at that point, ref_overrun sets (cleared only by rst).
- Eligibility, evaluated only in IDLE with init_done=1:
  - flush_pend or flush → FLUSH.
  - Else ref_pend → REF_REQ.
  - Else weligible = wfifo_level ≥ BURST_LEN; religible = rd_en & (rfifo_level ≤ RFIFO_DEPTH−BURST_LEN).
  - Both eligible: round-robin; the type not served last wins (last_wr=1 → read).
  - Only one eligible: that one. Neither: stay IDLE.
- FSM states: IDLE, WR_REQ, WR_BUSY, RD_REQ, RD_BUSY, REF_REQ, REF_BUSY, FLUSH.
- Request states (X_REQ):
  - Corresponding req output registered high from the cycle after the IDLE decision.
  - burst_addr = wr_addr or rd_addr, stable while req is high.
  - Req held until cmd_ack=1, then drops the next cycle and state → X_BUSY.
  - cmd_done in X_REQ is ignored.
- Busy states (X_BUSY): wait for cmd_done=1, then → IDLE.
  - WR/RD: the matching address advances by BURST_LEN on cmd_done, and last_wr updates (1 after write, 0 after read).
  - REF: ref_pend clears on cmd_ack in REF_REQ.
- Address wrap: if addr+BURST_LEN > ADDR_MAX, next addr=ADDR_MIN; compute in ADDR_WIDTH+1 bits.
- Flush:
  - flush seen in any non-IDLE state sets flush_pend; the in-flight command completes normally.
  - FLUSH lasts 1 cycle: wfifo_clr=rfifo_clr=1, wr_addr=rd_addr=ADDR_MIN, flush_pend=0, last_wr=0, then → IDLE.
  - Flush has priority over refresh; ref_pend is preserved.
- init_done dropping mid-operation: in-flight request/busy completes; IDLE then holds.
- At most one of wr_burst_req, rd_burst_req, ref_req is high in any cycle.
- Minimum IDLE→REQ latency: 1 cycle.

Test Plan:
- Reset mid WR_BUSY (rst pulse) → next cycle all outputs 0, burst_addr=0, state IDLE; subsequent write goes to address 0.
- init_done=1, wfifo_level=8, rd_en=0 → wr_burst_req=1, burst_addr=0; ack at cycle 3, done at cycle 10 → second request uses burst_addr=8.
- wfifo_level=20, rd_en=1, rfifo_level=0, ack/done immediately → requests alternate wr(0), rd(0), wr(8), rd(8); wfifo_level=7 → only reads issue.
- REF_PERIOD=16, ack delayed 40 cycles → ref_req is first request after expiry and has priority over a pending write; ref_overrun=1 after 2nd expiry while pending.
- ADDR_MAX=31, 5 write bursts → burst_addr sequence 0, 8, 16, 24, 0.
- flush during RD_BUSY → no clr until cmd_done; then 1-cycle wfifo_clr=rfifo_clr=1; next read burst_addr=0.
